// File: rtl/pipe_stage_reg.sv
// Pipeline stage register for the write-back payload with valid/ready handshake, flush and stall
// counter. Define PIPE_SKID_EN to add a skid entry that makes in_ready a pure register.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W = 16,
  parameter logic [ADDR_W-1:0] NOP_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_wd,
  input  logic              in_wreg,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_wd,
  output logic              out_wreg,
  output logic [DATA_W-1:0] out_wdata,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [ADDR_W-1:0] main_wd_q;
  logic              main_wreg_q;
  logic [DATA_W-1:0] main_wdata_q;
  logic              in_xfer;
  logic [CNT_W-1:0]  stall_cnt_q;

`ifdef PIPE_SKID_EN
  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e            state_q;
  logic              ready_q;
  logic [ADDR_W-1:0] skid_wd_q;
  logic              skid_wreg_q;
  logic [DATA_W-1:0] skid_wdata_q;

  assign out_valid = (state_q != StEmpty);
  assign in_ready  = ready_q;
  assign in_xfer   = in_valid && ready_q;

  // ready_q always mirrors (state != StTwo) of the state being entered.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q      <= StEmpty;
      ready_q      <= 1'b1;
      main_wd_q    <= NOP_ADDR;
      main_wreg_q  <= 1'b0;
      main_wdata_q <= '0;
      skid_wd_q    <= NOP_ADDR;
      skid_wreg_q  <= 1'b0;
      skid_wdata_q <= '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_xfer) begin
            main_wd_q    <= in_wd;
            main_wreg_q  <= in_wreg;
            main_wdata_q <= in_wdata;
            state_q      <= StOne;
          end
        end
        StOne: begin
          if (in_xfer && !out_ready) begin
            skid_wd_q    <= in_wd;
            skid_wreg_q  <= in_wreg;
            skid_wdata_q <= in_wdata;
            state_q      <= StTwo;
            ready_q      <= 1'b0;
          end else if (in_xfer) begin
            main_wd_q    <= in_wd;
            main_wreg_q  <= in_wreg;
            main_wdata_q <= in_wdata;
          end else if (out_ready) begin
            main_wd_q    <= NOP_ADDR;
            main_wreg_q  <= 1'b0;
            main_wdata_q <= '0;
            state_q      <= StEmpty;
          end
        end
        StTwo: begin
          if (out_ready) begin
            main_wd_q    <= skid_wd_q;
            main_wreg_q  <= skid_wreg_q;
            main_wdata_q <= skid_wdata_q;
            skid_wd_q    <= NOP_ADDR;
            skid_wreg_q  <= 1'b0;
            skid_wdata_q <= '0;
            state_q      <= StOne;
            ready_q      <= 1'b1;
          end
        end
        default: begin
          state_q <= StEmpty;
          ready_q <= 1'b1;
        end
      endcase
    end
  end
`else
  logic valid_q;

  assign out_valid = valid_q;
  assign in_ready  = !valid_q || out_ready;
  assign in_xfer   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q      <= 1'b0;
      main_wd_q    <= NOP_ADDR;
      main_wreg_q  <= 1'b0;
      main_wdata_q <= '0;
    end else if (in_xfer) begin
      valid_q      <= 1'b1;
      main_wd_q    <= in_wd;
      main_wreg_q  <= in_wreg;
      main_wdata_q <= in_wdata;
    end else if (out_ready) begin
      // Either draining the held beat or already empty: both end in the idle values.
      valid_q      <= 1'b0;
      main_wd_q    <= NOP_ADDR;
      main_wreg_q  <= 1'b0;
      main_wdata_q <= '0;
    end
  end
`endif

  assign out_wd    = main_wd_q;
  assign out_wreg  = main_wreg_q && out_valid;
  assign out_wdata = main_wdata_q;

  // Saturating; flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
